// File: rtl/syndrome_packetizer_pkg.sv
// Shared Helios definitions for the syndrome packetizer: message bytes and FSM state encoding.
package syndrome_packetizer_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  typedef enum logic [1:0] {
    START   = 2'd0,
    WAIT    = 2'd1,
    HEADER  = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  function automatic int bytes_for_bits(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/syndrome_packetizer.sv
// Serialises dense syndrome frames into START / header / byte-padded payload bytes for the decoder FIFO.
// Optional macro SYNDROME_PACKETIZER_SKIP_EMPTY_EN drops all-zero frames and pulses empty_skip instead.
//
// state   | meaning
// START   | announce decoding start, wait for the byte to be taken
// WAIT    | idle, ready to capture a frame
// HEADER  | send measurement header
// PAYLOAD | send padded frame, one byte per accept, LSB byte first
module syndrome_packetizer
  import syndrome_packetizer_pkg::*;
#(
  parameter int GRID_WIDTH_X = 4,
  parameter int GRID_WIDTH_Z = 1,
  parameter int GRID_WIDTH_U = 3
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] syndrome_data,
  input  logic                                             syndrome_valid,
  output logic                                             syndrome_ready,
  output logic [7:0]                                       out_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             busy,
  output logic [15:0]                                      frames_sent,
  output logic                                             empty_skip
);

  localparam int PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int BYTES_PER_ROUND = bytes_for_bits(PU_PER_ROUND);
  localparam int FRAME_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
  localparam int CNT_W           = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int BYTE_SLOTS      = 1 << CNT_W;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt;
  logic [FRAME_BYTES*8-1:0] padded, padded_next;
  logic [7:0]               pad_bytes [BYTE_SLOTS];
  logic                     last_byte;
  logic                     skip_frame;

  // Each round starts on a byte boundary; the remainder of its last byte is zero.
  for (genvar k = 0; k < GRID_WIDTH_U; k++) begin : g_round
    assign padded_next[k*BYTES_PER_ROUND*8 +: PU_PER_ROUND] =
      syndrome_data[k*PU_PER_ROUND +: PU_PER_ROUND];
    if (BYTES_PER_ROUND*8 > PU_PER_ROUND) begin : g_pad
      assign padded_next[k*BYTES_PER_ROUND*8+PU_PER_ROUND +: BYTES_PER_ROUND*8-PU_PER_ROUND] = '0;
    end
  end

  for (genvar b = 0; b < BYTE_SLOTS; b++) begin : g_byte
    if (b < FRAME_BYTES) begin : g_real
      assign pad_bytes[b] = padded[b*8 +: 8];
    end else begin : g_unused
      assign pad_bytes[b] = 8'h00;
    end
  end

  assign last_byte = (cnt == CNT_W'(FRAME_BYTES - 1));

`ifdef SYNDROME_PACKETIZER_SKIP_EMPTY_EN
  logic empty_skip_q;

  assign skip_frame = ~|syndrome_data;
  assign empty_skip = empty_skip_q;

  always_ff @(posedge clk) begin
    if (reset) empty_skip_q <= 1'b0;
    else       empty_skip_q <= (state == WAIT) && syndrome_valid && skip_frame;
  end
`else
  assign skip_frame = 1'b0;
  assign empty_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= START;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      START:   if (out_ready)                  state_next = WAIT;
      WAIT:    if (syndrome_valid && !skip_frame) state_next = HEADER;
      HEADER:  if (out_ready)                  state_next = PAYLOAD;
      PAYLOAD: if (out_ready && last_byte)     state_next = WAIT;
      default:                                 state_next = START;
    endcase
  end

  always_comb begin
    syndrome_ready = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'h00;
    case (state)
      START: begin
        out_valid = 1'b1;
        out_data  = START_DECODING_MSG;
      end
      WAIT:    syndrome_ready = 1'b1;
      HEADER: begin
        out_valid = 1'b1;
        out_data  = MEASUREMENT_DATA_HEADER;
      end
      PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = pad_bytes[cnt];
      end
      default: ;
    endcase
  end

  assign busy = (state != WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      frames_sent <= 16'd0;
      padded      <= '0;
    end else begin
      case (state)
        WAIT:    if (syndrome_valid && !skip_frame) padded <= padded_next;
        HEADER:  if (out_ready) cnt <= '0;
        PAYLOAD: if (out_ready) begin
          if (last_byte) begin
            cnt         <= '0;
            frames_sent <= frames_sent + 16'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syndrome_packetizer.sv
// Self-checking bench for syndrome_packetizer: vector table, random frames/backpressure, stall, reset and empty-frame cases.
module tb_syndrome_packetizer;
  import syndrome_packetizer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] sd0;
  logic        sv0, sr0, ov0, ordy0, busy0, es0;
  logic [7:0]  od0;
  logic [15:0] fs0;
  logic [23:0] sd1;
  logic        sv1, sr1, ov1, ordy1, busy1, es1;
  logic [7:0]  od1;
  logic [15:0] fs1;

  syndrome_packetizer dut0 (
    .clk(clk), .reset(reset), .syndrome_data(sd0), .syndrome_valid(sv0), .syndrome_ready(sr0),
    .out_data(od0), .out_valid(ov0), .out_ready(ordy0), .busy(busy0), .frames_sent(fs0),
    .empty_skip(es0));

  syndrome_packetizer #(.GRID_WIDTH_X(4), .GRID_WIDTH_Z(3), .GRID_WIDTH_U(2)) dut1 (
    .clk(clk), .reset(reset), .syndrome_data(sd1), .syndrome_valid(sv1), .syndrome_ready(sr1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy1), .busy(busy1), .frames_sent(fs1),
    .empty_skip(es1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_frames = 0;
  logic [7:0] q0[$];
  int         t0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [11:0] dense;
    logic [7:0]  b0, b1, b2;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted-byte monitor: a byte offered here with ready high is taken on the next rising edge.
  always @(negedge clk) begin
    if (!reset && ov0 && ordy0) begin
      q0.push_back(od0);
      t0.push_back(cyc);
    end
    if (!reset && ov1 && ordy1) q1.push_back(od1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: header, then per round ceil(PU/8) bytes, bit t of byte j is PU index j*8+t or 0 past the round.
  task automatic make_exp(input logic [11:0] d);
    int pu, bpr;
    logic [7:0] b;
    pu  = 4;
    bpr = (pu + 7) / 8;
    exp_q.delete();
    exp_q.push_back(MEASUREMENT_DATA_HEADER);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < bpr; j++) begin
        b = 8'h00;
        for (int t = 0; t < 8; t++)
          if (j*8 + t < pu) b[t] = d[k*pu + j*8 + t];
        exp_q.push_back(b);
      end
  endtask

  task automatic send0(input logic [11:0] d, input bit expect_header);
    int n = 0;
    while (!sr0 && n < 200) begin tick; n++; end
    if (!sr0) chk("send0_ready_timeout", 32'd0, 32'd1);
    sd0 = d;
    sv0 = 1'b1;
    tick;
    sv0 = 1'b0;
    sd0 = 12'($urandom);
    if (expect_header) begin
      @(negedge clk);
      chk("hdr_latency_valid", 32'(ov0), 32'd1);
      chk("hdr_latency_data", 32'(od0), 32'(MEASUREMENT_DATA_HEADER));
    end
  endtask

  task automatic wait_q0(input int n, input bit rnd);
    int c = 0;
    while (q0.size() < n && c < 400) begin
      if (rnd) ordy0 = 1'($urandom_range(0, 1));
      tick;
      c++;
    end
    if (q0.size() < n) chk("wait_bytes_timeout", 32'(q0.size()), 32'(n));
    ordy0 = 1'b1;
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_len"}, 32'(q0.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < q0.size()) chk($sformatf("%s_b%0d", nm, i), 32'(q0[i]), 32'(exp_q[i]));
  endtask

  task automatic frame0(input logic [11:0] d, input bit rnd, input string nm);
    make_exp(d);
    q0.delete();
    send0(d, 1'b1);
    wait_q0(exp_q.size(), rnd);
    cmp_stream(nm);
    exp_frames++;
    chk({nm, "_frames"}, 32'(fs0), 32'(exp_frames));
  endtask

  initial begin
    vecs[0] = '{12'h004, 8'h04, 8'h00, 8'h00};
    vecs[1] = '{12'hABC, 8'h0C, 8'h0B, 8'h0A};
    vecs[2] = '{12'hFFF, 8'h0F, 8'h0F, 8'h0F};
    vecs[3] = '{12'h801, 8'h01, 8'h00, 8'h08};
    vecs[4] = '{12'h3A5, 8'h05, 8'h0A, 8'h03};

    reset = 1'b1; sd0 = '0; sv0 = 1'b0; ordy0 = 1'b1; sd1 = '0; sv1 = 1'b0; ordy1 = 1'b1;
    repeat (3) tick;
    chk("rst_valid", 32'(ov0), 32'd1);
    chk("rst_data", 32'(od0), 32'(START_DECODING_MSG));
    chk("rst_ready", 32'(sr0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_frames", 32'(fs0), 32'd0);
    chk("rst_skip", 32'(es0), 32'd0);
    reset = 1'b0;
    q0.delete(); q1.delete();
    tick;
    chk("start_count", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) chk("start_byte", 32'(q0[0]), 32'(START_DECODING_MSG));
    chk("wait_valid", 32'(ov0), 32'd0);
    chk("wait_ready", 32'(sr0), 32'd1);
    chk("wait_busy", 32'(busy0), 32'd0);

    // Table vectors, checked against literal bytes.
    for (int v = 0; v < 5; v++) begin
      q0.delete();
      send0(vecs[v].dense, 1'b1);
      wait_q0(4, 1'b0);
      chk($sformatf("vec%0d_len", v), 32'(q0.size()), 32'd4);
      if (q0.size() == 4) begin
        chk($sformatf("vec%0d_hdr", v), 32'(q0[0]), 32'(MEASUREMENT_DATA_HEADER));
        chk($sformatf("vec%0d_b0", v), 32'(q0[1]), 32'(vecs[v].b0));
        chk($sformatf("vec%0d_b1", v), 32'(q0[2]), 32'(vecs[v].b1));
        chk($sformatf("vec%0d_b2", v), 32'(q0[3]), 32'(vecs[v].b2));
      end
      exp_frames++;
      chk($sformatf("vec%0d_frames", v), 32'(fs0), 32'(exp_frames));
    end

    // Wide-grid instance: 12 PUs per round pad into 2 bytes.
    q1.delete();
    begin
      int n = 0;
      while (!sr1 && n < 200) begin tick; n++; end
      sd1 = 24'hFFFFFF; sv1 = 1'b1; tick; sv1 = 1'b0; sd1 = '0;
      n = 0;
      while (q1.size() < 5 && n < 200) begin tick; n++; end
    end
    chk("wide_len", 32'(q1.size()), 32'd5);
    if (q1.size() == 5) begin
      chk("wide_hdr", 32'(q1[0]), 32'(MEASUREMENT_DATA_HEADER));
      chk("wide_b0", 32'(q1[1]), 32'hFF);
      chk("wide_b1", 32'(q1[2]), 32'h0F);
      chk("wide_b2", 32'(q1[3]), 32'hFF);
      chk("wide_b3", 32'(q1[4]), 32'h0F);
    end
    chk("wide_frames", 32'(fs1), 32'd1);

    // Back-to-back frames: exactly one idle cycle between last payload byte and next header.
    q0.delete(); t0.delete();
    make_exp(12'h123);
    sd0 = 12'h123; sv0 = 1'b1;
    wait_q0(8, 1'b0);
    sv0 = 1'b0;
    chk("b2b_len", 32'(q0.size()), 32'd8);
    if (q0.size() == 8) begin
      chk("b2b_hdr2", 32'(q0[4]), 32'(MEASUREMENT_DATA_HEADER));
      chk("b2b_gap", 32'(t0[4] - t0[3]), 32'd2);
      chk("b2b_last", 32'(q0[7]), 32'(exp_q[3]));
    end
    exp_frames += 2;
    chk("b2b_frames", 32'(fs0), 32'(exp_frames));

    // 20-cycle stall on payload byte 1.
    make_exp(12'h5C3);
    q0.delete();
    ordy0 = 1'b0;
    send0(12'h5C3, 1'b1);
    tick;
    ordy0 = 1'b1;
    tick; tick;
    ordy0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ov0), 32'd1);
      chk("stall_data", 32'(od0), 32'(exp_q[2]));
    end
    tick;
    ordy0 = 1'b1;
    wait_q0(4, 1'b0);
    cmp_stream("stall");
    exp_frames++;
    chk("stall_frames", 32'(fs0), 32'(exp_frames));

    // Random frames with random backpressure against the reference model.
    for (int r = 0; r < 12; r++) begin
      logic [11:0] d;
      d = 12'($urandom);
      if (d == 12'h000) d = 12'h001;
      frame0(d, 1'b1, $sformatf("rnd%0d", r));
    end

    // Empty frame.
`ifdef SYNDROME_PACKETIZER_SKIP_EMPTY_EN
    q0.delete();
    send0(12'h000, 1'b0);
    chk("skip_pulse", 32'(es0), 32'd1);
    chk("skip_no_valid", 32'(ov0), 32'd0);
    chk("skip_stays_wait", 32'(sr0), 32'd1);
    tick;
    chk("skip_pulse_end", 32'(es0), 32'd0);
    repeat (5) tick;
    chk("skip_no_bytes", 32'(q0.size()), 32'd0);
    chk("skip_frames", 32'(fs0), 32'(exp_frames));
`else
    frame0(12'h000, 1'b0, "zero");
    chk("zero_no_skip", 32'(es0), 32'd0);
`endif

    // Reset after payload byte 1: partial frame abandoned, START resent.
    ordy0 = 1'b1;
    q0.delete();
    send0(12'hABC, 1'b1);
    wait_q0(3, 1'b0);
    reset = 1'b1;
    tick;
    chk("midrst_frames", 32'(fs0), 32'd0);
    reset = 1'b0;
    exp_frames = 0;
    q0.delete();
    wait_q0(1, 1'b0);
    chk("midrst_len", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) chk("midrst_start", 32'(q0[0]), 32'(START_DECODING_MSG));
    tick;
    chk("midrst_frames_after", 32'(fs0), 32'd0);
    frame0(12'h004, 1'b0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/syndrome_packetizer.md
SYNDROME_PACKETIZER -- requirements
Module: syndrome_packetizer

Interface
REQ-001 SHALL have parameter GRID_WIDTH_X, default 4, the X dimension of the processing-unit grid.
REQ-002 SHALL have parameter GRID_WIDTH_Z, default 1, the Z dimension of the grid.
REQ-003 SHALL have parameter GRID_WIDTH_U, default 3, the number of measurement rounds per frame.
REQ-004 SHALL have port clk, input, 1 bit, the clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port syndrome_data, input, GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U bits, the dense syndrome; bit index = i*GRID_WIDTH_Z + j + k*GRID_WIDTH_X*GRID_WIDTH_Z.
REQ-007 SHALL have port syndrome_valid, input, 1 bit, asserted when syndrome_data holds a frame.
REQ-008 SHALL have port syndrome_ready, output, 1 bit, asserted when the block can accept a frame.
REQ-009 SHALL have port out_data, output, 8 bits, the byte to the decoder input FIFO.
REQ-010 SHALL have port out_valid, output, 1 bit, asserted when out_data holds a byte.
REQ-011 SHALL have port out_ready, input, 1 bit, asserted when the downstream FIFO accepts the byte.
REQ-012 SHALL have port busy, output, 1 bit, asserted whenever the FSM is not in WAIT.
REQ-013 SHALL have port frames_sent, output, 16 bits, the count of completed frames; wraps at 0xFFFF->0.
REQ-014 SHALL have port empty_skip, output, 1 bit, pulsed for one cycle when an empty frame is dropped (see Configuration).

Function
REQ-015 SHALL derive PU_PER_ROUND = X*Z, BYTES_PER_ROUND = ceil(PU_PER_ROUND/8), and FRAME_BYTES = BYTES_PER_ROUND*U.
REQ-016 SHALL run FSM states START, WAIT, HEADER and PAYLOAD.
REQ-017 SHALL make START the state after reset, with out_valid=1 and out_data=START_DECODING_MSG; it moves to WAIT on out_ready.
REQ-018 SHALL, in WAIT, drive syndrome_ready=1 and out_valid=0; on syndrome_valid it captures the frame into the padded register and moves to HEADER.
REQ-019 SHALL hold syndrome_ready=0 in every state other than WAIT.
REQ-020 SHALL build the padded register from the dense frame: each round k occupies bits [k*BYTES_PER_ROUND*8 +: PU_PER_ROUND], and all pad bits are 0.
REQ-021 SHALL, in HEADER, drive out_valid=1 and out_data=MEASUREMENT_DATA_HEADER; it moves to PAYLOAD on out_ready and clears the byte counter.
REQ-022 SHALL, in PAYLOAD, drive out_data = padded[cnt*8 +: 8], send bytes LSB byte first, and advance cnt on each out_ready.
REQ-023 SHALL, on the accepted byte with cnt = FRAME_BYTES-1, increment frames_sent and move to WAIT.
REQ-024 SHALL keep out_valid from depending combinationally on out_ready.
REQ-025 SHALL hold out_data stable from the first cycle out_valid is asserted until that byte is accepted.
REQ-026 SHALL assert out_valid for the header on the cycle after the frame is accepted (latency 1).
REQ-027 SHALL ignore syndrome_data changes after capture.
REQ-028 SHALL have exactly one idle cycle (WAIT) between the last payload byte and the next header.
REQ-029 SHALL hold state while out_ready=0 for any number of cycles, with no loss and no duplication.

Reset
REQ-030 SHALL, on reset, drive syndrome_ready=0, out_valid=1 (START), out_data=START_DECODING_MSG, busy=1, frames_sent=0, empty_skip=0, and clear cnt.
REQ-031 SHALL, on reset mid-frame, abandon the partial frame without completing it and resend START.

Configuration
REQ-032 SHALL, when SYNDROME_PACKETIZER_SKIP_EMPTY_EN is defined, accept an all-zero frame in WAIT, stay in WAIT, send no bytes, leave frames_sent unchanged, and pulse empty_skip for 1 cycle.
REQ-033 SHALL, when SYNDROME_PACKETIZER_SKIP_EMPTY_EN is undefined, transmit all-zero frames normally and tie empty_skip to 0.

Structure
REQ-034 SHALL take START_DECODING_MSG, MEASUREMENT_DATA_HEADER and the FSM state enum from the shared Helios package.
REQ-035 SHALL be implemented without sub-modules, as a single FSM with a datapath.

Verification
REQ-036 SHALL verify defaults after reset, with out_ready=1: the first byte is START_DECODING_MSG, then out_valid=0.
REQ-037 SHALL verify that syndrome bit (2,0,0) set (dense 12'h004) produces the bytes MEASUREMENT_DATA_HEADER, 0x04, 0x00, 0x00, after which frames_sent=1.
REQ-038 SHALL verify with X=4, Z=3, U=2 (PU=12, 2 bytes/round) and dense 24'hFFFFFF that the payload is 0xFF, 0x0F, 0xFF, 0x0F.
REQ-039 SHALL verify that random out_ready gaps and a 20-cycle stall mid-payload leave the byte stream identical and out_data stable while stalled.
REQ-040 SHALL verify that reset asserted after payload byte 1 causes the next bytes to be START_DECODING_MSG and then a new frame, with frames_sent=0.
REQ-041 SHALL verify that an all-zero frame with SYNDROME_PACKETIZER_SKIP_EMPTY_EN gives an empty_skip pulse and no bytes, and without the macro gives header, 0x00, 0x00, 0x00.
